als_err_monitor: RTL and testbench

- Hardware response checker for the approximate-adder benchmark circuits: the receiving end of the operand/sum stream that a stimulus source drives into an N-bit adder under test.
- Per accepted sample, takes operands plus the adder's (W+1)-bit result, recomputes the exact sum and accumulates error metrics: error count, sum of error distance, max error distance.
- Sits beside the adder under test in FPGA/emulation harnesses; replaces the offline dump-and-compare of output files.

---
 rtl/als_mon_pkg.sv | 16 +
 rtl/als_ed_calc.sv | 25 ++
 rtl/als_err_monitor.sv | 126 ++++++++++++
 tb/tb_als_err_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/als_mon_pkg.sv
// Shared definitions for the approximate-adder response monitors:
// default widths and the campaign FSM state encoding.
package als_mon_pkg;

  localparam int DEF_W     = 16;
  localparam int DEF_CNT_W = 20;
  localparam int DEF_ACC_W = DEF_CNT_W + DEF_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

endpackage

// File: rtl/als_ed_calc.sv
// Combinational exact sum and absolute error distance against the
// approximate result. Kept separate so other monitors can swap in a
// different exact function.
module als_ed_calc
  import als_mon_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W:0]   approx,
  output logic [W:0]   ed
);

  logic [W:0]          exact;
  logic signed [W+1:0] diff;

  // exact sum, signed difference one bit wider, then its magnitude
  always_comb begin
    exact = {1'b0, in0} + {1'b0, in1};
    diff  = $signed({1'b0, exact}) - $signed({1'b0, approx});
    ed    = diff[W+1] ? (approx - exact) : diff[W:0];
  end

endmodule

// File: rtl/als_err_monitor.sv
// Response checker for approximate adders: accepts operand/result
// samples, recomputes the exact sum and accumulates error count, summed
// error distance (saturating) and maximum error distance over a campaign.
module als_err_monitor
  import als_mon_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_in0,
  input  logic [W-1:0]     s_in1,
  input  logic [W:0]       s_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [W:0]       max_ed
);

  mon_state_t       state, state_nxt;
  logic [CNT_W-1:0] target;
  logic             transfer;
  logic             last_transfer;
  logic             start_ok;

  logic             s1_valid;
  logic [W-1:0]     s1_in0;
  logic [W-1:0]     s1_in1;
  logic [W:0]       s1_approx;
  logic             s2_valid;
  logic [W:0]       s2_ed;
  logic [W:0]       ed_calc;
  logic [ACC_W:0]   sum_ext;

  assign s_ready       = (state == RUN) && (sample_cnt != target);
  assign transfer      = s_valid && s_ready;
  assign last_transfer = transfer && ((sample_cnt + CNT_W'(1)) == target);
  assign start_ok      = start && ((state == IDLE) || (state == DONE));
  assign busy          = (state == RUN) || (state == DRAIN);
  assign done          = (state == DONE);
  assign sum_ext       = {1'b0, sum_ed} + (ACC_W+1)'(s2_ed);

  als_ed_calc #(.W(W)) u_ed_calc (
    .in0    (s1_in0),
    .in1    (s1_in1),
    .approx (s1_approx),
    .ed     (ed_calc)
  );

  // campaign state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // campaign sequencing: start only from IDLE/DONE, drain pipeline before DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_transfer) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // two-stage pipeline: capture the sample, then register its error distance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_in0    <= '0;
      s1_in1    <= '0;
      s1_approx <= '0;
      s2_valid  <= 1'b0;
      s2_ed     <= '0;
    end else begin
      s1_valid <= transfer;
      if (transfer) begin
        s1_in0    <= s_in0;
        s1_in1    <= s_in1;
        s1_approx <= s_approx;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_ed <= ed_calc;
    end
  end

  // campaign target and result accumulators; start clears them in place
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target     <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
    end else if (start_ok) begin
      target     <= num_samples;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
    end else begin
      if (transfer) sample_cnt <= sample_cnt + CNT_W'(1);
      if (s2_valid) begin
        if (s2_ed != '0) err_cnt <= err_cnt + CNT_W'(1);
        sum_ed <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        if (s2_ed > max_ed) max_ed <= s2_ed;
      end
    end
  end

endmodule

// File: tb/tb_als_err_monitor.sv
// Randomized self-checking bench for als_err_monitor. A second instance
// with a narrow accumulator exercises sum_ed saturation on the same stream.
module tb_als_err_monitor;

  localparam int W      = 16;
  localparam int CNT_W  = 20;
  localparam int ACC_W  = 37;
  localparam int SACC_W = 18;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             s_valid;
  logic [W-1:0]     s_in0;
  logic [W-1:0]     s_in1;
  logic [W:0]       s_approx;

  logic             s_ready, busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [ACC_W-1:0] sum_ed;
  logic [W:0]       max_ed;

  logic              sat_s_ready, sat_busy, sat_done;
  logic [CNT_W-1:0]  sat_sample_cnt, sat_err_cnt;
  logic [SACC_W-1:0] sat_sum_ed;
  logic [W:0]        sat_max_ed;

  als_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .s_valid(s_valid), .s_ready(s_ready), .s_in0(s_in0), .s_in1(s_in1),
    .s_approx(s_approx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed)
  );

  als_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(SACC_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .s_valid(s_valid), .s_ready(sat_s_ready), .s_in0(s_in0), .s_in1(s_in1),
    .s_approx(s_approx), .busy(sat_busy), .done(sat_done),
    .sample_cnt(sat_sample_cnt), .err_cnt(sat_err_cnt), .sum_ed(sat_sum_ed),
    .max_ed(sat_max_ed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int approx;
  } sample_t;

  sample_t stimQ[$];

  int     checks = 0;
  int     passes = 0;
  int     accepted;
  int     modelErr;
  longint modelSum;
  int     modelMax;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic applyStimulus(input bit v, input int a, input int b, input int ap);
    s_valid  = v;
    s_in0    = a[15:0];
    s_in1    = b[15:0];
    s_approx = ap[16:0];
  endtask

  task automatic applyJunk(input bit v);
    applyStimulus(v, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 131071)));
  endtask

  task automatic pushSample(input int a, input int b, input int ap);
    sample_t s;
    s.a = a; s.b = b; s.approx = ap;
    stimQ.push_back(s);
  endtask

  function automatic int makeApprox(input int exact);
    int ap;
    case ($urandom_range(0, 3))
      0:       ap = exact;
      1:       ap = exact + int'($urandom_range(0, 8)) - 4;
      2:       ap = int'($urandom_range(0, 131071));
      default: ap = exact ^ (1 << $urandom_range(0, 16));
    endcase
    if (ap < 0) ap = 0;
    if (ap > 131071) ap = 131071;
    return ap;
  endfunction

  task automatic fillRandom(input int n);
    int a, b;
    for (int i = 0; i < n; i++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      pushSample(a, b, makeApprox(a + b));
    end
  endtask

  // reference: error metrics straight from the definitions
  task automatic modelAccept(input sample_t s);
    int exact, ed;
    exact = s.a + s.b;
    ed = (exact > s.approx) ? exact - s.approx : s.approx - exact;
    accepted++;
    if (ed != 0) modelErr++;
    modelSum += longint'(ed);
    if (ed > modelMax) modelMax = ed;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_sample_cnt"}, 64'(sample_cnt), 0);
    checkOutput({tag, "_err_cnt"}, 64'(err_cnt), 0);
    checkOutput({tag, "_sum_ed"}, 64'(sum_ed), 0);
    checkOutput({tag, "_max_ed"}, 64'(max_ed), 0);
    checkOutput({tag, "_busy"}, 64'(busy), 0);
    checkOutput({tag, "_done"}, 64'(done), 0);
    checkOutput({tag, "_s_ready"}, 64'(s_ready), 0);
    checkOutput({tag, "_sat_sum_ed"}, 64'(sat_sum_ed), 0);
    checkOutput({tag, "_sat_busy"}, 64'(sat_busy), 0);
  endtask

  task automatic checkResults();
    longint lim, slim;
    lim  = (longint'(1) << ACC_W) - 1;
    slim = (longint'(1) << SACC_W) - 1;
    checkOutput("final_done", 64'(done), 1);
    checkOutput("final_busy", 64'(busy), 0);
    checkOutput("final_s_ready", 64'(s_ready), 0);
    checkOutput("final_sample_cnt", 64'(sample_cnt), 64'(accepted));
    checkOutput("final_err_cnt", 64'(err_cnt), 64'(modelErr));
    checkOutput("final_sum_ed", 64'(sum_ed), 64'((modelSum > lim) ? lim : modelSum));
    checkOutput("final_max_ed", 64'(max_ed), 64'(modelMax));
    checkOutput("sat_done", 64'(sat_done), 1);
    checkOutput("sat_sample_cnt", 64'(sat_sample_cnt), 64'(accepted));
    checkOutput("sat_err_cnt", 64'(sat_err_cnt), 64'(modelErr));
    checkOutput("sat_sum_ed", 64'(sat_sum_ed), 64'((modelSum > slim) ? slim : modelSum));
    checkOutput("sat_max_ed", 64'(sat_max_ed), 64'(modelMax));
  endtask

  // one campaign; entered and left just after a falling edge
  task automatic runCampaign(input int n, input int validPct, input bit holdStart, input bit usePattern);
    bit pat [6] = '{1, 0, 1, 1, 0, 1};
    bit v;
    int cycles, edges;
    accepted = 0; modelErr = 0; modelSum = 0; modelMax = 0;
    checkOutput("ready_before_start", 64'(s_ready), 0);
    start = 1'b1;
    num_samples = n[CNT_W-1:0];
    applyJunk(1'b1);
    @(posedge clk);
    @(negedge clk);
    start = holdStart;
    num_samples = n[CNT_W-1:0] + CNT_W'(5);
    applyJunk(1'b0);
    checkOutput("start_sample_cnt", 64'(sample_cnt), 0);
    checkOutput("start_err_cnt", 64'(err_cnt), 0);
    checkOutput("start_sum_ed", 64'(sum_ed), 0);
    checkOutput("start_max_ed", 64'(max_ed), 0);
    if (n == 0) begin
      start = 1'b0;
      checkOutput("zero_done", 64'(done), 1);
      checkOutput("zero_busy", 64'(busy), 0);
      checkOutput("zero_s_ready", 64'(s_ready), 0);
      return;
    end
    checkOutput("run_busy", 64'(busy), 1);
    checkOutput("run_done", 64'(done), 0);
    cycles = 0;
    while (accepted < n && cycles < 4000) begin
      v = usePattern ? pat[cycles % 6] : ($urandom_range(1, 100) <= validPct);
      if (v) applyStimulus(1'b1, stimQ[0].a, stimQ[0].b, stimQ[0].approx);
      else   applyJunk(1'b0);
      checkOutput("run_s_ready", 64'(s_ready), 1);
      checkOutput("run_sat_s_ready", 64'(sat_s_ready), 1);
      checkOutput("run_sample_cnt", 64'(sample_cnt), 64'(accepted));
      @(posedge clk);
      if (v) modelAccept(stimQ.pop_front());
      @(negedge clk);
      cycles++;
    end
    if (accepted < n) checkOutput("run_timeout", 64'(sample_cnt), 64'(n));
    start = 1'b0;
    applyJunk(1'b1);
    checkOutput("ready_after_last", 64'(s_ready), 0);
    checkOutput("sample_cnt_after_last", 64'(sample_cnt), 64'(n));
    checkOutput("drain_busy", 64'(busy), 1);
    edges = 0;
    while (!done && edges < 10) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      applyJunk(1'b1);
    end
    checkOutput("done_latency", 64'(edges), 3);
    applyJunk(1'b0);
    checkResults();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    applyStimulus(1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] zero-length campaign from IDLE");
    runCampaign(0, 100, 1'b0, 1'b0);

    $display("[TB] exact results");
    pushSample(1, 2, 3);
    pushSample(65535, 1, 65536);
    pushSample(0, 0, 0);
    pushSample(40000, 30000, 70000);
    runCampaign(4, 100, 1'b0, 1'b0);

    $display("[TB] errors in both directions and full-width");
    pushSample(1, 2, 4);
    pushSample(65535, 1, 65533);
    pushSample(0, 0, 0);
    pushSample(10, 20, 65566);
    runCampaign(4, 100, 1'b0, 1'b0);

    $display("[TB] gapped valid pattern");
    fillRandom(3);
    runCampaign(3, 0, 1'b0, 1'b1);

    $display("[TB] zero-length campaign from DONE");
    runCampaign(0, 100, 1'b0, 1'b0);

    $display("[TB] reset mid-campaign");
    fillRandom(10);
    start = 1'b1;
    num_samples = CNT_W'(10);
    applyJunk(1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, stimQ[0].a, stimQ[0].b, stimQ[0].approx);
      void'(stimQ.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("pre_reset_sample_cnt", 64'(sample_cnt), 5);
    rst_n = 1'b0;
    applyJunk(1'b1);
    @(posedge clk);
    @(negedge clk);
    checkZero("midreset");
    rst_n = 1'b1;
    applyJunk(1'b0);
    stimQ.delete();
    @(negedge clk);

    $display("[TB] fresh campaign with start held during RUN");
    fillRandom(2);
    runCampaign(2, 100, 1'b1, 1'b0);

    $display("[TB] saturation boundary on narrow accumulator");
    for (int i = 0; i < 4; i++) pushSample(0, 0, 65535);
    pushSample(0, 0, 2);
    pushSample(0, 0, 5);
    runCampaign(6, 70, 1'b1, 1'b0);

    $display("[TB] random campaigns");
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 40));
      fillRandom(n);
      runCampaign(n, int'($urandom_range(30, 100)), k[0], 1'b0);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
